// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding, timeout read-data default and counter sizing for the UART arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [31:0] TO_DATA_DEF = 32'hDEAD_BEEF;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_timer.sv
// wb_arb_timer: per-grant ack timeout counter; expire is high once TIMEOUT_CYCLES-1 ack-less owner cycles have elapsed
module wb_arb_timer
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    // clear while idle, count each owner cycle that has no ack
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/wb_uart_arb.sv
// wb_uart_arb: two-master round-robin Wishbone arbiter in front of the UART slave.
// Optional ack timeout abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_uart_arb
    import wb_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TO_DATA        = TO_DATA_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic        busy, own1, req0, req1, cyc, to_fire;
    logic [31:0] rdat;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign busy = state_q != IDLE;
    assign own1 = state_q == OWN1;
    assign cyc  = own1 ? m1_cyc_i : m0_cyc_i;

    // state encoding is already one-hot per owner, so it doubles as the grant vector
    assign grant_o = state_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic expire;

    wb_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clr    (!busy),
        .en     (busy && !s_ack_i),
        .expire (expire)
    );

    // a real ack in the expiry cycle wins; an aborting master gets no forced ack
    assign to_fire = busy && cyc && expire && !s_ack_i;
`else
    assign to_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    // state and round-robin history registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end

    // arbitrate in IDLE only; release on ack, timeout or master abort
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (req0 && (!req1 || last_q)) state_d = OWN0;
            else if (req1)                 state_d = OWN1;
        end else if (s_ack_i || to_fire || !cyc) begin
            state_d = IDLE;
            last_d  = own1;
        end
    end

    // slave-side mux from the owner and ack/data routing back to it
    always_comb begin
        rdat      = to_fire ? TO_DATA : s_dat_i;
        s_cyc_o   = busy & cyc & ~to_fire;
        s_stb_o   = busy & (own1 ? m1_stb_i : m0_stb_i) & ~to_fire;
        s_we_o    = busy & (own1 ? m1_we_i : m0_we_i);
        s_sel_o   = busy ? (own1 ? m1_sel_i : m0_sel_i) : '0;
        s_adr_o   = busy ? (own1 ? m1_adr_i : m0_adr_i) : '0;
        s_dat_o   = busy ? (own1 ? m1_dat_i : m0_dat_i) : '0;
        m0_ack_o  = busy & ~own1 & (s_ack_i | to_fire);
        m1_ack_o  = own1 & (s_ack_i | to_fire);
        m0_dat_o  = (busy && !own1) ? rdat : '0;
        m1_dat_o  = own1 ? rdat : '0;
        timeout_o = to_fire;
    end

endmodule

// File: tb/tb_wb_uart_arb.sv
// tb_wb_uart_arb: table-driven checks of arbitration, routing and abort, plus timeout and async-reset sequences
module tb_wb_uart_arb;

    localparam logic [31:0] A0 = 32'h3000_0004;
    localparam logic [31:0] A1 = 32'h3000_0008;
    localparam logic [31:0] D0 = 32'h0000_0055;
    localparam logic [31:0] D1 = 32'h0000_0077;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack;
    logic [31:0] s_dat;
    logic        m0_ack, m1_ack, s_cyc, s_stb, s_we, timeout;
    logic [31:0] m0_dat, m1_dat, s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        r0, r1, ack;
        logic [31:0] sdat;
        logic [1:0]  g;
        logic        scyc, a0, a1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    wb_uart_arb #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (1'b1),
        .m0_sel_i (4'hF),
        .m0_adr_i (A0),
        .m0_dat_i (D0),
        .m0_ack_o (m0_ack),
        .m0_dat_o (m0_dat),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (1'b0),
        .m1_sel_i (4'h3),
        .m1_adr_i (A1),
        .m1_dat_i (D1),
        .m1_ack_o (m1_ack),
        .m1_dat_o (m1_dat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_dat),
        .grant_o  (grant),
        .timeout_o(timeout)
    );

    function automatic vec_t mk(logic r0, logic r1, logic ack, logic [31:0] sdat, logic [1:0] g,
                                logic scyc, logic a0, logic a1, logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.ack = ack; v.sdat = sdat; v.g = g;
        v.scyc = scyc; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic ack, input logic [31:0] sdat);
        m0_cyc = r0; m0_stb = r0; m1_cyc = r1; m1_stb = r1; s_ack = ack; s_dat = sdat;
    endtask

    initial begin
        // tie after reset, alternation, non-owner stall
        tv.push_back(mk(1, 1, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 1, 'hA5, 2'b01, 1, 1, 0, 'hA5, 0));
        tv.push_back(mk(1, 1, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 1, 'h5A, 2'b10, 1, 0, 1, 0,     'h5A));
        tv.push_back(mk(1, 1, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 1, 'hA5, 2'b01, 1, 1, 0, 'hA5, 0));
        tv.push_back(mk(1, 1, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 0, 0,     2'b10, 1, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 1, 'h5A, 2'b10, 1, 0, 1, 0,     'h5A));
        tv.push_back(mk(0, 0, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        // m0 alone, slave acks two cycles after strobe
        tv.push_back(mk(1, 0, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 0, 0,     2'b01, 1, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 0, 0,     2'b01, 1, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 1, 0,     2'b01, 1, 1, 0, 0,     0));
        tv.push_back(mk(0, 0, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        // m1 aborts with m0 pending, then a stray idle ack is ignored
        tv.push_back(mk(0, 1, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 1, 0, 0,     2'b10, 1, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 0, 0,     2'b10, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 0, 0,     2'b00, 0, 0, 0, 0,     0));
        tv.push_back(mk(1, 0, 1, 'h11, 2'b01, 1, 1, 0, 'h11, 0));
        tv.push_back(mk(0, 0, 1, 'h99, 2'b00, 0, 0, 0, 0,     0));

        rst_n = 1'b0;
        drive(0, 0, 1, 32'h1234_5678);
        #3;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_cyc", 32'(s_cyc), 0);
        chk("rst_s_stb", 32'(s_stb), 0);
        chk("rst_m0_ack", 32'(m0_ack), 0);
        chk("rst_m1_ack", 32'(m1_ack), 0);
        chk("rst_m0_dat", m0_dat, 0);
        chk("rst_m1_dat", m1_dat, 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        tick();

        for (int i = 0; i < tv.size(); i++) begin
            logic [31:0] exp_adr, exp_wdat;
            drive(tv[i].r0, tv[i].r1, tv[i].ack, tv[i].sdat);
            exp_adr  = (tv[i].g == 2'b01) ? A0 : (tv[i].g == 2'b10) ? A1 : 32'h0;
            exp_wdat = (tv[i].g == 2'b01) ? D0 : (tv[i].g == 2'b10) ? D1 : 32'h0;
            #2;
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].g));
            chk($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(tv[i].scyc));
            chk($sformatf("v%0d_s_adr", i), s_adr, exp_adr);
            chk($sformatf("v%0d_s_dat", i), s_wdat, exp_wdat);
            chk($sformatf("v%0d_s_we", i), 32'(s_we), 32'(tv[i].g == 2'b01));
            chk($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(tv[i].a0));
            chk($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(tv[i].a1));
            chk($sformatf("v%0d_m0_dat", i), m0_dat, tv[i].d0);
            chk($sformatf("v%0d_m1_dat", i), m1_dat, tv[i].d1);
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 0);
            tick();
        end

        // slave never acks m0
        drive(1, 0, 0, 0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("to%0d_m0_ack", i), 32'(m0_ack), 32'(i == 7));
            chk($sformatf("to%0d_timeout", i), 32'(timeout), 32'(i == 7));
            chk($sformatf("to%0d_s_cyc", i), 32'(s_cyc), 32'(i != 7));
            chk($sformatf("to%0d_s_stb", i), 32'(s_stb), 32'(i != 7));
            if (i == 7) chk("to_m0_dat", m0_dat, 32'hDEAD_BEEF);
            tick();
        end
        drive(0, 0, 0, 0);
        #2;
        chk("to_after_grant", 32'(grant), 0);
        chk("to_after_timeout", 32'(timeout), 0);
        tick();
`else
        for (int i = 0; i < 12; i++) begin
            #2;
            chk($sformatf("wait%0d_m0_ack", i), 32'(m0_ack), 0);
            chk($sformatf("wait%0d_timeout", i), 32'(timeout), 0);
            chk($sformatf("wait%0d_grant", i), 32'(grant), 32'b01);
            tick();
        end
        drive(0, 0, 0, 0);
        #2;
        chk("wait_abort_s_cyc", 32'(s_cyc), 0);
        chk("wait_abort_m0_ack", 32'(m0_ack), 0);
        tick();
        #2;
        chk("wait_after_grant", 32'(grant), 0);
        tick();
`endif

        // async reset while m1 owns the bus
        drive(0, 1, 0, 0);
        tick();
        #2;
        chk("ar_own1_grant", 32'(grant), 32'b10);
        s_ack = 1'b1;
        s_dat = 32'hCAFE_0001;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 0);
        chk("ar_s_cyc", 32'(s_cyc), 0);
        chk("ar_m1_ack", 32'(m1_ack), 0);
        chk("ar_m1_dat", m1_dat, 0);
        tick();
        drive(1, 1, 0, 0);
        rst_n = 1'b1;
        tick();
        #2;
        chk("ar_tie_grant", 32'(grant), 32'b01);
        chk("ar_tie_s_adr", s_adr, A0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
